// File: rtl/turbo_iteration_controller_if.sv
// Frame, SISO-launch and decision signals of the turbo iteration controller.
// master = controller side, slave = frame source, SISO and decision sink.
interface turbo_iteration_controller_if #(
    parameter int N        = 10,
    parameter int MAX_ITER = 8
);
    localparam int IW = $clog2(MAX_ITER + 1);

    logic          in_valid;
    logic          in_ready;
    logic          siso_in_valid;
    logic          siso_half_iter;
    logic          ext_sel;
    logic          siso_out_valid;
    logic [N-1:0]  siso_result;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_bits;
    logic [IW-1:0] out_iters;
    logic          out_early;
    logic          out_timeout;

    modport master (
        input  in_valid, siso_out_valid, siso_result, out_ready,
        output in_ready, siso_in_valid, siso_half_iter, ext_sel,
        output out_valid, out_bits, out_iters, out_early, out_timeout
    );

    modport slave (
        output in_valid, siso_out_valid, siso_result, out_ready,
        input  in_ready, siso_in_valid, siso_half_iter, ext_sel,
        input  out_valid, out_bits, out_iters, out_early, out_timeout
    );
endinterface

// File: rtl/turbo_iteration_controller.sv
// Sequences SISO half-iterations for one turbo frame, stopping on the
// iteration limit, on unchanged hard decisions, or on a SISO timeout.
module turbo_iteration_controller #(
    parameter int N          = 10,
    parameter int MAX_ITER   = 8,
    parameter int TIMEOUT    = 512,
    parameter bit EARLY_STOP = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    turbo_iteration_controller_if.master bus
);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [IW-1:0] ITER_LAST  = IW'(MAX_ITER - 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic          ext_sel_q, ext_sel_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [N-1:0]  prev_bits_q, prev_bits_d;
    logic [N-1:0]  cur_bits_q, cur_bits_d;
    logic          early_q, early_d;
    logic          timeout_q, timeout_d;

    logic          repeat_hit;

    // iter_q counts completed full iterations; the first one has no
    // predecessor to compare against.
    assign repeat_hit = EARLY_STOP && (iter_q != '0)
                        && (cur_bits_q == prev_bits_q);

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        ext_sel_d   = ext_sel_q;
        iter_d      = iter_q;
        timer_d     = timer_q;
        prev_bits_d = prev_bits_q;
        cur_bits_d  = cur_bits_q;
        early_d     = early_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d     = S_LAUNCH;
                    half_d      = 1'b0;
                    ext_sel_d   = 1'b0;
                    iter_d      = '0;
                    prev_bits_d = '0;
                    cur_bits_d  = '0;
                    early_d     = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            S_LAUNCH: begin
                timer_d = TIMER_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.siso_out_valid) begin
                    state_d = S_CHECK;
                    if (half_q) cur_bits_d = bus.siso_result;
                end else if (timer_q == '0) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_CHECK: begin
                if (!half_q) begin
                    half_d    = 1'b1;
                    ext_sel_d = 1'b1;
                    state_d   = S_LAUNCH;
                end else begin
                    iter_d      = iter_q + IW'(1);
                    prev_bits_d = cur_bits_q;
                    if (repeat_hit) begin
                        state_d = S_DONE;
                        early_d = 1'b1;
                    end else if (iter_q == ITER_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        half_d  = 1'b0;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            half_q      <= 1'b0;
            ext_sel_q   <= 1'b0;
            iter_q      <= '0;
            timer_q     <= '0;
            prev_bits_q <= '0;
            cur_bits_q  <= '0;
            early_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            ext_sel_q   <= ext_sel_d;
            iter_q      <= iter_d;
            timer_q     <= timer_d;
            prev_bits_q <= prev_bits_d;
            cur_bits_q  <= cur_bits_d;
            early_q     <= early_d;
            timeout_q   <= timeout_d;
        end
    end

    logic done;
    assign done = (state_q == S_DONE);

    assign bus.in_ready       = (state_q == S_IDLE);
    assign bus.siso_in_valid  = (state_q == S_LAUNCH);
    assign bus.siso_half_iter = half_q;
    assign bus.ext_sel        = ext_sel_q;
    assign bus.out_valid      = done;
    // Result fields read as zero outside DONE so stale frames never leak.
    assign bus.out_bits       = done ? cur_bits_q : '0;
    assign bus.out_iters      = done ? iter_q : '0;
    assign bus.out_early      = done & early_q;
    assign bus.out_timeout    = done & timeout_q;
endmodule

// File: tb/tb_turbo_iteration_controller.sv
// Directed bench: two controllers (early stop on/off) driven by 5-cycle
// stub SISOs with programmable result tables.
`timescale 1ns/1ps
module tb_turbo_iteration_controller;
    localparam int N        = 10;
    localparam int MAX_ITER = 4;
    localparam int TIMEOUT  = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    turbo_iteration_controller_if #(.N(N), .MAX_ITER(MAX_ITER)) b0 ();
    turbo_iteration_controller_if #(.N(N), .MAX_ITER(MAX_ITER)) b1 ();

    turbo_iteration_controller #(
        .N(N), .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT), .EARLY_STOP(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(b0)
    );

    turbo_iteration_controller #(
        .N(N), .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT), .EARLY_STOP(1'b0)
    ) dut_ne (
        .clk(clk), .rstn(rstn), .bus(b1)
    );

    int           n_tests = 0;
    int           n_fail = 0;
    logic [N-1:0] res [32];
    bit           stub_en = 1'b1;
    int           lc = 0;
    int           nl = 0;
    int           cyc_ctr = 0;
    logic         hist_half [32];
    logic         hist_ext [32];
    int           hist_t [32];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub SISO for dut: answers 5 cycles after each launch from res[].
    initial begin
        int idx;
        b0.siso_out_valid = 1'b0;
        b0.siso_result = '0;
        forever begin
            @(negedge clk);
            if (rstn && stub_en && b0.siso_in_valid) begin
                idx = lc % 32;
                lc++;
                repeat (4) @(negedge clk);
                b0.siso_result = res[idx];
                b0.siso_out_valid = 1'b1;
                @(negedge clk);
                b0.siso_out_valid = 1'b0;
            end
        end
    end

    // Stub SISO for dut_ne: constant decisions.
    initial begin
        b1.siso_out_valid = 1'b0;
        b1.siso_result = '0;
        forever begin
            @(negedge clk);
            if (rstn && b1.siso_in_valid) begin
                repeat (4) @(negedge clk);
                b1.siso_result = 10'h155;
                b1.siso_out_valid = 1'b1;
                @(negedge clk);
                b1.siso_out_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc_ctr++;
            if (b0.siso_in_valid && nl < 32) begin
                hist_half[nl] = b0.siso_half_iter;
                hist_ext[nl]  = b0.ext_sel;
                hist_t[nl]    = cyc_ctr;
                nl++;
            end
        end
    end

    task automatic send(input int sel);
        @(negedge clk);
        if (sel == 0) b0.in_valid = 1'b1;
        else          b1.in_valid = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        b1.in_valid = 1'b0;
        chk("launch_lat", (sel == 0) ? b0.siso_in_valid : b1.siso_in_valid, 1);
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (!((sel == 0) ? b0.out_valid : b1.out_valid) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", (sel == 0) ? b0.out_valid : b1.out_valid, 1);
    endtask

    task automatic release0();
        b0.out_ready = 1'b1;
        @(negedge clk);
        b0.out_ready = 1'b0;
        chk("rel_valid", b0.out_valid, 0);
        chk("rel_ready", b0.in_ready, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_in_ready"}, b0.in_ready, 1);
        chk({tag, "_siso_iv"}, b0.siso_in_valid, 0);
        chk({tag, "_half"}, b0.siso_half_iter, 0);
        chk({tag, "_ext"}, b0.ext_sel, 0);
        chk({tag, "_ov"}, b0.out_valid, 0);
        chk({tag, "_bits"}, b0.out_bits, 0);
        chk({tag, "_iters"}, b0.out_iters, 0);
        chk({tag, "_early"}, b0.out_early, 0);
        chk({tag, "_tmo"}, b0.out_timeout, 0);
    endtask

    task automatic fill_distinct();
        for (int i = 0; i < 32; i++) res[i] = N'(i * 37 + 5);
    endtask

    initial begin
        int cyc;
        b0.in_valid = 1'b0;
        b0.out_ready = 1'b0;
        b1.in_valid = 1'b0;
        b1.out_ready = 1'b0;
        fill_distinct();
        repeat (3) @(negedge clk);
        chk_quiet("rst");
        rstn = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");

        // 1: decisions change every iteration -> full 4 iterations
        lc = 0;
        nl = 0;
        send(0);
        wait_done(0, cyc);
        chk("t1_launches", nl, 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_half", hist_half[i], i % 2);
            chk("t1_ext", hist_ext[i], (i != 0) ? 1 : 0);
        end
        chk("t1_gap", hist_t[1] - hist_t[0], 6);
        chk("t1_cycles", cyc, 48);
        chk("t1_iters", b0.out_iters, 4);
        chk("t1_early", b0.out_early, 0);
        chk("t1_tmo", b0.out_timeout, 0);
        chk("t1_bits", b0.out_bits, res[7]);
        release0();

        // 2: decisions settle at iteration 2 -> early stop after 3
        res[0] = 10'h100;
        res[1] = 10'h011;
        for (int i = 2; i < 32; i++) res[i] = 10'h2A5;
        lc = 0;
        nl = 0;
        b0.out_ready = 1'b1;
        send(0);
        wait_done(0, cyc);
        chk("t2_launches", nl, 6);
        chk("t2_cycles", cyc, 36);
        chk("t2_iters", b0.out_iters, 3);
        chk("t2_early", b0.out_early, 1);
        chk("t2_bits", b0.out_bits, 10'h2A5);
        @(negedge clk);
        chk("t2_pulse", b0.out_valid, 0);
        chk("t2_ready", b0.in_ready, 1);
        b0.out_ready = 1'b0;

        // 3: early stop disabled, constant decisions
        send(1);
        wait_done(1, cyc);
        chk("t3_iters", b1.out_iters, 4);
        chk("t3_early", b1.out_early, 0);
        chk("t3_bits", b1.out_bits, 10'h155);
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        chk("t3_rel", b1.in_ready, 1);

        // 4: SISO silent -> timeout TIMEOUT+1 cycles after launch
        stub_en = 1'b0;
        nl = 0;
        send(0);
        wait_done(0, cyc);
        chk("t4_cycles", cyc, 17);
        chk("t4_tmo", b0.out_timeout, 1);
        chk("t4_iters", b0.out_iters, 0);
        chk("t4_early", b0.out_early, 0);
        chk("t4_launches", nl, 1);
        release0();
        stub_en = 1'b1;

        // 5: back-pressure in DONE
        fill_distinct();
        lc = 0;
        send(0);
        wait_done(0, cyc);
        b0.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_ov", b0.out_valid, 1);
            chk("t5_bits", b0.out_bits, res[7]);
            chk("t5_iters", b0.out_iters, 4);
            chk("t5_in_ready", b0.in_ready, 0);
            chk("t5_siso_iv", b0.siso_in_valid, 0);
        end
        b0.in_valid = 1'b0;
        release0();
        lc = 0;
        nl = 0;
        send(0);
        wait_done(0, cyc);
        chk("t5_next_iters", b0.out_iters, 4);
        chk("t5_next_launches", nl, 8);
        release0();

        // 6: reset during WAIT of iteration 2
        lc = 0;
        nl = 0;
        send(0);
        for (int k = 0; k < 200 && nl < 3; k++) @(negedge clk);
        chk("t6_reach", nl, 3);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_quiet("t6_rst");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_idle_ready", b0.in_ready, 1);
            chk("t6_idle_iv", b0.siso_in_valid, 0);
            chk("t6_idle_ov", b0.out_valid, 0);
        end
        lc = 0;
        nl = 0;
        send(0);
        wait_done(0, cyc);
        chk("t6_iters", b0.out_iters, 4);
        chk("t6_launches", nl, 8);
        chk("t6_bits", b0.out_bits, res[7]);
        release0();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
